// File: rtl/baser_257b_mii_decoder.sv
// 256b/257b transcoded block to MII word decoder with receive sequence checking.
// Optional BASER_DEC_STATS_EN adds accepted-block and sequence-error counters.
module baser_257b_mii_decoder #(
    parameter int DATA_WIDTH        = 64,
    parameter int CONTROL_WIDTH     = 8,
    parameter int TRANSCODER_BLOCKS = 4,
    parameter int TC_WIDTH          = 257
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic [TC_WIDTH-1:0]      i_rx_xcoded,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [DATA_WIDTH-1:0]    o_rxd,
    output logic [CONTROL_WIDTH-1:0] o_rxc,
    output logic                     o_rx_valid,
    output logic                     o_seq_err,
    output logic [1:0]               o_state
`ifdef BASER_DEC_STATS_EN
    ,
    output logic [31:0]              o_block_count,
    output logic [31:0]              o_err_count
`endif
);

    // Handshake: a block transfers on a rising edge where i_valid and o_ready
    // are both high; o_ready depends only on registered state, and the source
    // must hold i_rx_xcoded stable while i_valid is high and o_ready is low.

    localparam int PEND_W = $clog2(TRANSCODER_BLOCKS);
    localparam int EXT_W  = TC_WIDTH + 8;
    localparam logic [DATA_WIDTH-1:0] IDLE_RXD = {8{8'h07}};
    localparam logic [DATA_WIDTH-1:0] ERR_RXD  = {8{8'hFE}};

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_PKT  = 2'd2
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_C = 3'd0,
        CLS_S = 3'd1,
        CLS_D = 3'd2,
        CLS_T = 3'd3,
        CLS_E = 3'd4
    } word_class_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    rxd;
        logic [CONTROL_WIDTH-1:0] rxc;
        word_class_e              cls;
        logic                     xerr;
    } mii_word_t;

    // Returns {supported, type byte} for the low nibble of the first control type.
    function automatic logic [8:0] nib_to_type(input logic [3:0] nib);
        case (nib)
            4'hE:    nib_to_type = {1'b1, 8'h1E};
            4'h8:    nib_to_type = {1'b1, 8'h78};
            4'h7:    nib_to_type = {1'b1, 8'h87};
            4'h9:    nib_to_type = {1'b1, 8'h99};
            4'hA:    nib_to_type = {1'b1, 8'hAA};
            4'h4:    nib_to_type = {1'b1, 8'hB4};
            4'hC:    nib_to_type = {1'b1, 8'hCC};
            4'h2:    nib_to_type = {1'b1, 8'hD2};
            4'h1:    nib_to_type = {1'b1, 8'hE1};
            4'hF:    nib_to_type = {1'b1, 8'hFF};
            4'hB:    nib_to_type = {1'b1, 8'h4B};
            default: nib_to_type = 9'h000;
        endcase
    endfunction

    // Number of data bytes ahead of /T/; 8 means the type is not a terminate.
    function automatic logic [3:0] term_len(input logic [7:0] t);
        case (t)
            8'h87:   term_len = 4'd0;
            8'h99:   term_len = 4'd1;
            8'hAA:   term_len = 4'd2;
            8'hB4:   term_len = 4'd3;
            8'hCC:   term_len = 4'd4;
            8'hD2:   term_len = 4'd5;
            8'hE1:   term_len = 4'd6;
            8'hFF:   term_len = 4'd7;
            default: term_len = 4'd8;
        endcase
    endfunction

    function automatic mii_word_t decode_block(input logic is_data, input logic [63:0] blk);
        mii_word_t   w;
        logic [3:0]  tl;
        logic [63:0] pay;
        w.rxd  = ERR_RXD;
        w.rxc  = 8'hFF;
        w.cls  = CLS_E;
        w.xerr = 1'b0;
        tl     = term_len(blk[7:0]);
        pay    = {8'h00, blk[63:8]};
        if (is_data) begin
            w.rxd = blk;
            w.rxc = 8'h00;
            w.cls = CLS_D;
        end else if (blk[7:0] == 8'h1E) begin
            for (int l = 0; l < 8; l++) begin
                w.rxd[8*l +: 8] = (blk[8+7*l +: 7] == 7'h00) ? 8'h07 : 8'hFE;
            end
            w.cls = CLS_C;
        end else if (blk[7:0] == 8'h78) begin
            w.rxd = {blk[63:8], 8'hFB};
            w.rxc = 8'h01;
            w.cls = CLS_S;
        end else if (blk[7:0] == 8'h4B) begin
            w.rxd = {32'h07070707, blk[31:8], 8'h9C};
            w.rxc = 8'hF1;
            w.cls = CLS_C;
        end else if (tl != 4'd8) begin
            for (int l = 0; l < 8; l++) begin
                if (l < int'(tl)) begin
                    w.rxd[8*l +: 8] = pay[8*l +: 8];
                    w.rxc[l]        = 1'b0;
                end else begin
                    w.rxd[8*l +: 8] = (l == int'(tl)) ? 8'hFD : 8'h07;
                    w.rxc[l]        = 1'b1;
                end
            end
            w.cls = CLS_T;
        end
        return w;
    endfunction

    // Transcode expansion of the block currently presented on the input.
    mii_word_t        dec [TRANSCODER_BLOCKS];
    logic [EXT_W-1:0] xc_ext;
    logic [3:0]       flags;
    logic [8:0]       first_type;
    int               first_ctl;
    int               off;
    logic [63:0]      raw;
    logic [63:0]      blk;
    logic             blk_is_data;
    logic             tc_err;

    always_comb begin
        xc_ext      = {8'h00, i_rx_xcoded};
        flags       = i_rx_xcoded[4:1];
        first_type  = nib_to_type(i_rx_xcoded[8:5]);
        first_ctl   = TRANSCODER_BLOCKS;
        off         = 0;
        raw         = '0;
        blk         = '0;
        blk_is_data = 1'b0;
        for (int k = TRANSCODER_BLOCKS - 1; k >= 0; k--) begin
            if (!flags[k]) first_ctl = k;
        end
        tc_err = !i_rx_xcoded[0] && ((flags == 4'hF) || !first_type[8]);
        for (int k = 0; k < TRANSCODER_BLOCKS; k++) begin
            if (i_rx_xcoded[0]) begin
                blk         = i_rx_xcoded[64*k+1 +: 64];
                blk_is_data = 1'b1;
            end else begin
                // Blocks after the first control block sit 8 bits lower: its type byte was squeezed out.
                off         = 9 + 64*k - ((k > first_ctl) ? 8 : 0);
                raw         = xc_ext[off +: 64];
                blk_is_data = flags[k];
                blk         = (k == first_ctl) ? {raw[55:0], first_type[7:0]} : raw;
            end
            dec[k] = decode_block(blk_is_data, blk);
            if (tc_err) begin
                dec[k].rxd  = ERR_RXD;
                dec[k].rxc  = 8'hFF;
                dec[k].cls  = CLS_E;
                dec[k].xerr = 1'b1;
            end
        end
    end

    // Word buffer and emission select.
    mii_word_t         buf_q [TRANSCODER_BLOCKS-1];
    logic [PEND_W-1:0] pend_q;
    logic              accept;
    logic              emit;
    mii_word_t         cur;

    assign o_ready = (pend_q == '0);
    assign accept  = i_valid && o_ready;
    assign emit    = accept || (pend_q != '0);
    assign cur     = accept ? dec[0] : buf_q[0];

    // Receive sequence FSM.
    seq_state_e            state_q;
    seq_state_e            state_d;
    logic                  replace;
    logic                  seq_err_d;
    logic [DATA_WIDTH-1:0] out_rxd;
    logic [CONTROL_WIDTH-1:0] out_rxc;

    always_ff @(posedge clk) begin
        if (i_rst) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        replace = 1'b0;
        if (emit) begin
            case (state_q)
                ST_INIT: begin
                    if (cur.cls == CLS_C) state_d = ST_IDLE;
                    else                  replace = 1'b1;
                end
                ST_IDLE: begin
                    case (cur.cls)
                        CLS_S:        state_d = ST_PKT;
                        CLS_D, CLS_T: replace = 1'b1;
                        default:      state_d = ST_IDLE;
                    endcase
                end
                ST_PKT: begin
                    case (cur.cls)
                        CLS_D:        state_d = ST_PKT;
                        CLS_C, CLS_S: begin
                            replace = 1'b1;
                            state_d = ST_IDLE;
                        end
                        default:      state_d = ST_IDLE;
                    endcase
                end
                default: state_d = ST_INIT;
            endcase
        end
        out_rxd   = replace ? ERR_RXD : cur.rxd;
        out_rxc   = replace ? 8'hFF : cur.rxc;
        seq_err_d = emit && (replace || cur.xerr);
    end

    assign o_state = state_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_rxd      <= IDLE_RXD;
            o_rxc      <= 8'hFF;
            o_rx_valid <= 1'b0;
            o_seq_err  <= 1'b0;
            pend_q     <= '0;
            for (int k = 0; k < TRANSCODER_BLOCKS - 1; k++) buf_q[k] <= '0;
        end else begin
            o_rx_valid <= emit;
            o_seq_err  <= seq_err_d;
            if (emit) begin
                o_rxd <= out_rxd;
                o_rxc <= out_rxc;
            end
            if (accept) begin
                for (int k = 0; k < TRANSCODER_BLOCKS - 1; k++) buf_q[k] <= dec[k+1];
                pend_q <= PEND_W'(TRANSCODER_BLOCKS - 1);
            end else if (pend_q != '0) begin
                for (int k = 0; k < TRANSCODER_BLOCKS - 2; k++) buf_q[k] <= buf_q[k+1];
                pend_q <= pend_q - PEND_W'(1);
            end
        end
    end

`ifdef BASER_DEC_STATS_EN
    logic [31:0] block_count_q;
    logic [31:0] err_count_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            block_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            if (accept && (block_count_q != 32'hFFFF_FFFF)) block_count_q <= block_count_q + 32'd1;
            if (seq_err_d && (err_count_q != 32'hFFFF_FFFF)) err_count_q <= err_count_q + 32'd1;
        end
    end

    assign o_block_count = block_count_q;
    assign o_err_count   = err_count_q;
`endif

endmodule
